// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST neuron multiply-accumulate engine.
// Operands and results are Q8.8 signed; the accumulator is wide enough for 800 full-scale products.
package mnist_pkg;

  localparam int ADDR_STRIDE = 4;
  localparam int ACC_W       = 48;
  localparam int Q_W         = 16;
  localparam int Q_FRAC      = 8;
  localparam int LEN_W       = 10;
  localparam int LEN_MAX_DEF = 800;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    X,
    W,
    LAST,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/mnist_sat_relu.sv
// Converts the wide accumulator to a Q8.8 result: arithmetic shift, saturation
// to the 16-bit signed range, then optional clamp of negatives to zero.
module mnist_sat_relu
  import mnist_pkg::*;
#(
  parameter int FRAC = Q_FRAC
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic                    relu_en_i,
  output logic signed [Q_W-1:0]   result_o
);

  localparam logic signed [ACC_W-1:0] QMAX = 48'sd32767;
  localparam logic signed [ACC_W-1:0] QMIN = -48'sd32768;

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted  = acc_i >>> FRAC;
    result_o = shifted[Q_W-1:0];
    if (shifted > QMAX) begin
      result_o = 16'sh7FFF;
    end else if (shifted < QMIN) begin
      result_o = -16'sh8000;
    end
    if (relu_en_i && result_o[Q_W-1]) begin
      result_o = '0;
    end
  end

endmodule

// File: rtl/mnist_neuron_mac.sv
// One-neuron dot product engine: reads bias, then alternating x[i]/w[i] words
// from a 1-cycle-latency BRAM, accumulates, and writes back the Q8.8 result.
module mnist_neuron_mac
  import mnist_pkg::*;
#(
  parameter int LEN_MAX = LEN_MAX_DEF,
  parameter int FRAC    = Q_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       in_base,
  input  logic [31:0]       w_base,
  input  logic [31:0]       bias_addr,
  input  logic [31:0]       out_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  output logic [Q_W-1:0]    result,
  output logic              R_req,
  output logic [31:0]       addr,
  input  logic [31:0]       R_data,
  output logic [3:0]        W_req,
  output logic [31:0]       W_data
);

  state_t                   state_q, state_d;
  logic [31:0]              in_base_q, in_base_d;
  logic [31:0]              w_base_q, w_base_d;
  logic [31:0]              bias_addr_q, bias_addr_d;
  logic [31:0]              out_addr_q, out_addr_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic                     relu_q, relu_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [Q_W-1:0]    x_q, x_d;
  logic [LEN_W-1:0]         i_q, i_d;
  logic [Q_W-1:0]           result_q, result_d;

  logic                     accept;
  logic signed [Q_W-1:0]    rd_word;
  logic signed [2*Q_W-1:0]  prod;
  logic signed [Q_W-1:0]    sat_res;
  logic                     unused_rdata;

  assign unused_rdata = ^R_data[31:Q_W];
  assign rd_word      = $signed(R_data[Q_W-1:0]);
  assign prod         = x_q * rd_word;
  assign accept       = (state_q == IDLE) && start && (len != '0)
                        && (32'(len) <= 32'(LEN_MAX));

  mnist_sat_relu #(.FRAC(FRAC)) u_sat_relu (
    .acc_i     (acc_q),
    .relu_en_i (relu_q),
    .result_o  (sat_res)
  );

  always_comb begin
    state_d     = state_q;
    in_base_d   = in_base_q;
    w_base_d    = w_base_q;
    bias_addr_d = bias_addr_q;
    out_addr_d  = out_addr_q;
    len_d       = len_q;
    relu_d      = relu_q;
    acc_d       = acc_q;
    x_d         = x_q;
    i_d         = i_q;
    result_d    = result_q;
    busy        = (state_q != IDLE) && (state_q != DONE);
    done        = (state_q == DONE);
    R_req       = 1'b0;
    W_req       = 4'b0000;
    addr        = '0;
    W_data      = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          in_base_d   = in_base;
          w_base_d    = w_base;
          bias_addr_d = bias_addr;
          out_addr_d  = out_addr;
          len_d       = len;
          relu_d      = relu_en;
          state_d     = BIAS;
        end
      end
      BIAS: begin
        R_req   = 1'b1;
        addr    = bias_addr_q;
        i_d     = '0;
        state_d = X;
      end
      X: begin
        R_req = 1'b1;
        addr  = in_base_q + 32'(i_q) * 32'(ADDR_STRIDE);
        // On i==0 the word arriving now is the bias; afterwards it is w[i-1].
        if (i_q == '0) begin
          acc_d = ACC_W'(rd_word) <<< FRAC;
        end else begin
          acc_d = acc_q + ACC_W'(prod);
        end
        state_d = W;
      end
      W: begin
        R_req = 1'b1;
        addr  = w_base_q + 32'(i_q) * 32'(ADDR_STRIDE);
        x_d   = rd_word;
        if (i_q == len_q - 1'b1) begin
          state_d = LAST;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = X;
        end
      end
      LAST: begin
        acc_d   = acc_q + ACC_W'(prod);
        state_d = WR;
      end
      WR: begin
        R_req    = 1'b1;
        W_req    = 4'b1111;
        addr     = out_addr_q;
        W_data   = 32'(sat_res);
        result_d = sat_res;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_base_q   <= '0;
      w_base_q    <= '0;
      bias_addr_q <= '0;
      out_addr_q  <= '0;
      len_q       <= '0;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      x_q         <= '0;
      i_q         <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      in_base_q   <= in_base_d;
      w_base_q    <= w_base_d;
      bias_addr_q <= bias_addr_d;
      out_addr_q  <= out_addr_d;
      len_q       <= len_d;
      relu_q      <= relu_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      i_q         <= i_d;
      result_q    <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_mnist_neuron_mac.sv
// Directed bench for mnist_neuron_mac with a 1-cycle-latency word BRAM model.
module tb_mnist_neuron_mac;

  localparam logic [31:0] BIAS_A = 32'h0000_0100;
  localparam logic [31:0] X_A    = 32'h0000_0200;
  localparam logic [31:0] W_A    = 32'h0000_0400;
  localparam logic [31:0] OUT_A  = 32'h0000_0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in_base = '0, w_base = '0, bias_addr = '0, out_addr = '0;
  logic [9:0]  len = '0;
  logic        relu_en = 1'b0;
  logic        busy, done, R_req;
  logic [15:0] result;
  logic [31:0] addr, W_data;
  logic [31:0] R_data = '0;
  logic [3:0]  W_req;

  logic [31:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (W_req == 4'hF) mem[addr[13:2]] = W_data;
    if (R_req) R_data <= mem[addr[13:2]];
  end

  mnist_neuron_mac dut (
    .clk(clk), .rst(rst), .start(start), .in_base(in_base), .w_base(w_base),
    .bias_addr(bias_addr), .out_addr(out_addr), .len(len), .relu_en(relu_en),
    .busy(busy), .done(done), .result(result), .R_req(R_req), .addr(addr),
    .R_data(R_data), .W_req(W_req), .W_data(W_data)
  );

  typedef struct {
    logic [9:0]  len;
    logic [15:0] bias;
    logic [15:0] x0, x1, w0, w1;
    logic        relu;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drives one start and watches 2*l+12 cycles; cycle 1 is the cycle after start is sampled.
  task automatic run_op(input logic [9:0] l, input logic re, input logic [31:0] oa,
                        input logic accepted, input int pulse_at, input int rst_at,
                        output int done_at, output int nwr, output logic [31:0] wd,
                        output logic busy_seen);
    @(negedge clk);
    in_base = X_A; w_base = W_A; bias_addr = BIAS_A; out_addr = oa;
    len = l; relu_en = re; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_at = -1; nwr = 0; wd = 32'hXXXX_XXXX; busy_seen = 1'b0;
    for (int c = 1; c <= 2 * int'(l) + 12; c++) begin
      if (busy) busy_seen = 1'b1;
      if (W_req == 4'hF) begin
        nwr++;
        wd = W_data;
      end
      if (done && done_at < 0) done_at = c;
      if (c == 1) chk("c1_addr", addr, accepted ? BIAS_A : 32'h0);
      if (rst_at > 0 && c == rst_at + 1) begin
        chk("abort_rreq", {31'b0, R_req}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
      end
      if (c == pulse_at) begin
        start = 1'b1;
        out_addr = oa ^ 32'h40;
        len = 10'd1;
      end else begin
        start = 1'b0;
      end
      rst = (c == rst_at);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic load_vec(input vec_t v, input logic [31:0] oa);
    mem[BIAS_A[13:2]] = {16'h0, v.bias};
    mem[X_A[13:2]]     = {16'h0, v.x0};
    mem[X_A[13:2] + 1] = {16'h0, v.x1};
    mem[W_A[13:2]]     = {16'h0, v.w0};
    mem[W_A[13:2] + 1] = {16'h0, v.w1};
    mem[oa[13:2]]      = 32'hDEAD_BEEF;
  endtask

  initial begin
    int          done_at, nwr;
    logic [31:0] wd;
    logic        bs;
    logic [31:0] oa;

    for (int k = 0; k < 4096; k++) mem[k] = '0;

    vecs[0] = '{10'd1, 16'h0100, 16'h0200, 16'h0000, 16'h0180, 16'h0000, 1'b0, 32'h0000_0400};
    vecs[1] = '{10'd2, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 32'h0000_7FFF};
    vecs[2] = '{10'd2, 16'h0000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0, 32'hFFFF_8000};
    vecs[3] = '{10'd1, 16'hFF00, 16'h0100, 16'h0000, 16'h0080, 16'h0000, 1'b0, 32'hFFFF_FF80};
    vecs[4] = '{10'd1, 16'hFF00, 16'h0100, 16'h0000, 16'h0080, 16'h0000, 1'b1, 32'h0000_0000};
    vecs[5] = '{10'd2, 16'h0080, 16'h0300, 16'hFE00, 16'h0100, 16'h0040, 1'b0, 32'h0000_0300};
    vecs[6] = '{10'd1, 16'h0000, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 1'b0, 32'hFFFF_FFFF};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",   {31'b0, busy},  32'h0);
    chk("rst_done",   {31'b0, done},  32'h0);
    chk("rst_rreq",   {31'b0, R_req}, 32'h0);
    chk("rst_wreq",   {28'b0, W_req}, 32'h0);
    chk("rst_addr",   addr,           32'h0);
    chk("rst_wdata",  W_data,         32'h0);
    chk("rst_result", {16'b0, result}, 32'h0);

    for (int k = 0; k <= 6; k++) begin
      oa = OUT_A + 32'(k * 4);
      load_vec(vecs[k], oa);
      run_op(vecs[k].len, vecs[k].relu, oa, 1'b1, 0, 0, done_at, nwr, wd, bs);
      $display("vec%0d len=%0d relu=%0b W_data=0x%08h done_at=%0d writes=%0d",
               k, vecs[k].len, vecs[k].relu, wd, done_at, nwr);
      chk("vec_done_at", 32'(done_at), 32'(2 * int'(vecs[k].len) + 4));
      chk("vec_writes",  32'(nwr), 32'd1);
      chk("vec_wdata",   wd, vecs[k].exp);
      chk("vec_mem",     mem[oa[13:2]], vecs[k].exp);
      chk("vec_result",  {16'b0, result}, {16'b0, vecs[k].exp[15:0]});
    end

    // Illegal lengths are ignored outright.
    mem[OUT_A[13:2]] = 32'h1111_2222;
    run_op(10'd0, 1'b0, OUT_A, 1'b0, 0, 0, done_at, nwr, wd, bs);
    $display("len0 busy_seen=%0b done_at=%0d writes=%0d", bs, done_at, nwr);
    chk("len0_busy", {31'b0, bs}, 32'h0);
    chk("len0_done", 32'(done_at), 32'hFFFF_FFFF);
    chk("len0_wr",   32'(nwr), 32'h0);
    run_op(10'd801, 1'b0, OUT_A, 1'b0, 0, 0, done_at, nwr, wd, bs);
    $display("len801 busy_seen=%0b done_at=%0d writes=%0d", bs, done_at, nwr);
    chk("len801_busy", {31'b0, bs}, 32'h0);
    chk("len801_wr",   32'(nwr), 32'h0);
    chk("len801_mem",  mem[OUT_A[13:2]], 32'h1111_2222);

    // Start coinciding with reset is ignored.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; len = 10'd1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rst_start_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
    end
    $display("start under reset: busy stayed low");

    // Second start mid-run (with different operands) must not disturb the run.
    oa = OUT_A + 32'h20;
    load_vec(vecs[5], oa);
    mem[(oa ^ 32'h40) >> 2] = 32'h5555_AAAA;
    run_op(10'd2, 1'b0, oa, 1'b1, 3, 0, done_at, nwr, wd, bs);
    $display("busy start: W_data=0x%08h done_at=%0d writes=%0d", wd, done_at, nwr);
    chk("pulse_done_at", 32'(done_at), 32'd8);
    chk("pulse_writes",  32'(nwr), 32'd1);
    chk("pulse_mem",     mem[oa[13:2]], 32'h0000_0300);
    chk("pulse_other",   mem[(oa ^ 32'h40) >> 2], 32'h5555_AAAA);

    // Reset at cycle 5 of a len=4 run aborts with no write.
    mem[OUT_A[13:2]] = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      mem[X_A[13:2] + 10'(k)] = 32'h0000_0100;
      mem[W_A[13:2] + 10'(k)] = 32'h0000_0100;
    end
    run_op(10'd4, 1'b0, OUT_A, 1'b1, 0, 5, done_at, nwr, wd, bs);
    $display("abort: done_at=%0d writes=%0d", done_at, nwr);
    chk("abort_writes", 32'(nwr), 32'h0);
    chk("abort_done",   32'(done_at), 32'hFFFF_FFFF);
    chk("abort_mem",    mem[OUT_A[13:2]], 32'h1234_5678);
    chk("abort_result", {16'b0, result}, 32'h0);

    // Full-length vector: 800 products of 1/256*1/256 -> 800/256 truncated.
    mem[BIAS_A[13:2]] = 32'h0;
    for (int k = 0; k < 800; k++) begin
      mem[(32'h1000 >> 2) + k] = 32'h0000_0001;
      mem[(32'h2000 >> 2) + k] = 32'h0000_0001;
    end
    mem[OUT_A[13:2]] = 32'hDEAD_BEEF;
    @(negedge clk);
    in_base = 32'h1000; w_base = 32'h2000; bias_addr = BIAS_A; out_addr = OUT_A;
    len = 10'd800; relu_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_at = -1; nwr = 0;
    for (int c = 1; c <= 1620; c++) begin
      if (W_req == 4'hF) nwr++;
      if (done && done_at < 0) done_at = c;
      @(negedge clk);
    end
    $display("full len=800: result=0x%04h done_at=%0d writes=%0d", result, done_at, nwr);
    chk("full_done_at", 32'(done_at), 32'd1604);
    chk("full_result",  {16'b0, result}, 32'h0000_0003);
    chk("full_writes",  32'(nwr), 32'd1);
    chk("full_mem",     mem[OUT_A[13:2]], 32'h0000_0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
